demux_1x8_scan_controller: RTL and testbench

DEMUX_1X8_SCAN_CONTROLLER -- requirements
Module: demux_1x8_scan_controller

---
 rtl/demux_1x8_scan_controller.sv | 99 +++++++++
 tb/tb_demux_1x8_scan_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x8_scan_controller.sv
// Serialises an 8-bit frame onto a downstream 1x8 demux: bit k is driven on
// I_out while sel=k for DWELL cycles, channels 0..7 in ascending order.
module demux_1x8_scan_controller #(
  parameter int unsigned DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       hold,
  output logic       I_out,
  output logic [2:0] sel,
  output logic       out_en,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned FRAME_W    = 8;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned DWELL_W    = 8;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state;
  logic [CH_W-1:0]      channel;
  logic [DWELL_W-1:0]   dwell;
  logic [FRAME_W-1:0]   frame;
  logic                 armed;

  logic dwell_end_c;
  logic last_c;
  logic accept_c;

  // Last dwell cycle of the current channel, and of the whole frame.
  assign dwell_end_c = (dwell == DWELL_LAST);
  assign last_c      = (state == SCAN) && (channel == LAST_CH) && dwell_end_c;

  // armed keeps in_ready low while in reset and until the first edge after it.
  assign in_ready = armed && ((state == IDLE) || last_c) && !hold;
  assign accept_c = in_valid && in_ready;

  // Scan FSM with registered demux drive, status and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      channel    <= '0;
      dwell      <= '0;
      frame      <= '0;
      armed      <= 1'b0;
      sel        <= '0;
      I_out      <= 1'b0;
      out_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frame_done <= 1'b0;
      if (!hold) begin
        if (last_c) begin
          frame_done <= 1'b1;
        end
        if (accept_c) begin
          state   <= SCAN;
          channel <= '0;
          dwell   <= '0;
          frame   <= data_in;
          sel     <= '0;
          I_out   <= data_in[0];
          out_en  <= 1'b1;
          busy    <= 1'b1;
        end else if (state == SCAN) begin
          if (!dwell_end_c) begin
            dwell <= dwell + DWELL_W'(1);
          end else if (channel != LAST_CH) begin
            channel <= channel + CH_W'(1);
            dwell   <= '0;
            sel     <= channel + CH_W'(1);
            I_out   <= frame[channel + CH_W'(1)];
          end else begin
            state   <= IDLE;
            channel <= '0;
            dwell   <= '0;
            sel     <= '0;
            I_out   <= 1'b0;
            out_en  <= 1'b0;
            busy    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1x8_scan_controller.sv
// Bench for demux_1x8_scan_controller: one instance with DWELL=1, one with DWELL=3.
module tb_demux_1x8_scan_controller;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_hold, b_hold;
  logic       a_ready, b_ready, a_i, b_i, a_en, b_en, a_busy, b_busy, a_done, b_done;
  logic [2:0] a_sel, b_sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic       bit_v;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  demux_1x8_scan_controller #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .hold(a_hold), .I_out(a_i), .sel(a_sel), .out_en(a_en), .busy(a_busy), .frame_done(a_done)
  );

  demux_1x8_scan_controller #(.DWELL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .hold(b_hold), .I_out(b_i), .sel(b_sel), .out_en(b_en), .busy(b_busy), .frame_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected (sel, bit) for every driven cycle of one frame.
  task automatic push_frame(input logic [7:0] d, input int dw);
    exp_t n;
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < dw; k++) begin
        n.sel   = 3'(ch);
        n.bit_v = d[ch];
        q.push_back(n);
      end
    end
  endtask

  function automatic exp_t pop_exp();
    pop_exp = 'x;
    if (q.size() > 0) pop_exp = q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_hold = 1'b0;
    b_data = '0; b_valid = 1'b0; b_hold = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_sel, a_i, a_en, a_busy, a_done, a_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: got %b want 00000000", {a_sel, a_i, a_en, a_busy, a_done, a_ready});
    end
    checks++;
    if ({b_sel, b_i, b_en, b_busy, b_done, b_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: got %b want 00000000", {b_sel, b_i, b_en, b_busy, b_done, b_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", a_ready);
    end
    tick();
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_edge: got %b want 11", {a_ready, b_ready});
    end
  endtask

  task automatic test_dwell1();
    logic exp_en, exp_done;
    a_data = 8'hA5; a_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL dwell1_ready: got %b want 1", a_ready);
    end
    push_frame(8'hA5, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_en = (c <= 8);
      exp_done = (c == 9);
      checks++;
      if ({a_en, a_busy, a_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL dwell1_ctrl c=%0d: got en/busy/done=%b want %b", c, {a_en, a_busy, a_done}, {exp_en, exp_en, exp_done});
      end
      e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({a_sel, a_i} !== e) begin
        errors++;
        $display("FAIL dwell1_data c=%0d: got sel/I=%b want %b", c, {a_sel, a_i}, e);
      end
      tick();
    end
  endtask

  task automatic test_dwell3();
    logic exp_en, exp_done;
    b_data = 8'h01; b_valid = 1'b1;
    #1;
    push_frame(8'h01, 3);
    tick();
    b_valid = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      exp_en = (c <= 24);
      exp_done = (c == 25);
      checks++;
      if ({b_en, b_busy, b_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL dwell3_ctrl c=%0d: got en/busy/done=%b want %b", c, {b_en, b_busy, b_done}, {exp_en, exp_en, exp_done});
      end
      e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({b_sel, b_i} !== e) begin
        errors++;
        $display("FAIL dwell3_data c=%0d: got sel/I=%b want %b", c, {b_sel, b_i}, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_done;
    a_data = 8'hFF; a_valid = 1'b1;
    #1;
    push_frame(8'hFF, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      exp_en = (c <= 16);
      exp_done = (c == 9) || (c == 17);
      checks++;
      if ({a_en, a_busy, a_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d: got en/busy/done=%b want %b", c, {a_en, a_busy, a_done}, {exp_en, exp_en, exp_done});
      end
      e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({a_sel, a_i} !== e) begin
        errors++;
        $display("FAIL b2b_data c=%0d: got sel/I=%b want %b", c, {a_sel, a_i}, e);
      end
      if (c == 8) begin
        checks++;
        if (a_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready: got %b want 1", a_ready);
        end
        a_data = 8'h00; a_valid = 1'b1;
        push_frame(8'h00, 1);
      end
      if (c == 9) a_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_hold();
    logic exp_en, exp_done, frozen;
    a_data = 8'h96; a_valid = 1'b1;
    #1;
    push_frame(8'h96, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      exp_en = (c <= 12);
      exp_done = (c == 13);
      frozen = (c >= 5) && (c <= 8);
      checks++;
      if ({a_en, a_busy, a_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL hold_ctrl c=%0d: got en/busy/done=%b want %b", c, {a_en, a_busy, a_done}, {exp_en, exp_en, exp_done});
      end
      if (!frozen) e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({a_sel, a_i} !== e) begin
        errors++;
        $display("FAIL hold_data c=%0d: got sel/I=%b want %b", c, {a_sel, a_i}, e);
      end
      if (c >= 4 && c <= 7) begin
        a_hold = 1'b1; a_valid = 1'b1; a_data = 8'hFF;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_ready c=%0d: got %b want 0", c, a_ready);
        end
      end
      if (c == 8) begin
        a_hold = 1'b0; a_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_hold_done();
    logic exp_en, exp_done, frozen;
    a_data = 8'h80; a_valid = 1'b1;
    #1;
    push_frame(8'h80, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_en = (c <= 10);
      exp_done = (c == 11);
      frozen = (c == 9) || (c == 10);
      checks++;
      if ({a_en, a_busy, a_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL hold_done_ctrl c=%0d: got en/busy/done=%b want %b", c, {a_en, a_busy, a_done}, {exp_en, exp_en, exp_done});
      end
      if (!frozen) e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({a_sel, a_i} !== e) begin
        errors++;
        $display("FAIL hold_done_data c=%0d: got sel/I=%b want %b", c, {a_sel, a_i}, e);
      end
      if (c == 8) begin
        a_hold = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_done_ready: got %b want 0", a_ready);
        end
      end
      if (c == 10) a_hold = 1'b0;
      tick();
    end
  endtask

  task automatic test_ignore();
    logic exp_en, exp_done;
    a_data = 8'hC3; a_valid = 1'b1;
    #1;
    push_frame(8'hC3, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_en = (c <= 8);
      exp_done = (c == 9);
      checks++;
      if ({a_en, a_busy, a_done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL ignore_ctrl c=%0d: got en/busy/done=%b want %b", c, {a_en, a_busy, a_done}, {exp_en, exp_en, exp_done});
      end
      e = exp_en ? pop_exp() : exp_t'(4'b0000);
      checks++;
      if ({a_sel, a_i} !== e) begin
        errors++;
        $display("FAIL ignore_data c=%0d: got sel/I=%b want %b", c, {a_sel, a_i}, e);
      end
      if (c >= 2 && c <= 5) begin
        a_data = 8'h3C; a_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
          errors++;
          $display("FAIL ignore_ready c=%0d: got %b want 0", c, a_ready);
        end
      end
      if (c == 6) a_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    a_data = 8'hFF; a_valid = 1'b1;
    #1;
    push_frame(8'hFF, 1);
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      e = pop_exp();
      checks++;
      if ({a_en, a_sel, a_i} !== {1'b1, e}) begin
        errors++;
        $display("FAIL rstmid_data c=%0d: got en/sel/I=%b want %b", c, {a_en, a_sel, a_i}, {1'b1, e});
      end
      if (c < 6) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_sel, a_i, a_en, a_busy, a_done, a_ready} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got %b want 00000000", {a_sel, a_i, a_en, a_busy, a_done, a_ready});
    end
    q.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_pre: got %b want 0", a_ready);
    end
    tick();
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready_post: got %b want 1", a_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({a_done, a_en, a_busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_no_done c=%0d: got done/en/busy=%b want 000", c, {a_done, a_en, a_busy});
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dwell1();
    test_dwell3();
    test_back_to_back();
    test_hold();
    test_hold_done();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
